// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction fields (add / li / bner0)
// into 8-bit words, buffers them in a small FIFO and writes them in order
// into program memory through a stallable write port.
// Build macro NOP_PAD_EN: once the program has drained, fill every remaining
// address up to MEM_SIZE-1 with 8'h00 (add r0,r0,r0) before reporting done.
module instr_encoder_loader #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MEM_SIZE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_opcode,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs1,
    input  logic [1:0] in_rs2,
    input  logic [3:0] in_addr,
    input  logic [3:0] in_imm,
    input  logic       in_last,
    output logic       mem_we,
    input  logic       mem_ready,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       err_illegal,
    output logic [4:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef NOP_PAD_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_PAD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
`endif

    state_t          state_q, state_n;
    logic [7:0]      fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_cnt, fifo_cnt_n;
    logic [4:0]      legal_cnt, legal_cnt_n;

    logic            accept, illegal, push, pop, fire, out_free, fifo_empty;
    logic [7:0]      enc;
    logic            in_ready_n, mem_we_n, busy_n, done_n, err_n;
    logic [3:0]      addr_n;
    logic [7:0]      wdata_n;
    logic [4:0]      count_n;

    // Handshakes, field packing and next-state / next-output computation
    always_comb begin
        accept     = in_valid && in_ready;
        illegal    = (in_opcode == 2'b01);
        push       = accept && !illegal;
        fire       = mem_we && mem_ready;
        out_free   = !mem_we || mem_ready;
        fifo_empty = (fifo_cnt == '0);
        pop        = out_free && !fifo_empty;

        case (in_opcode)
            2'b00:   enc = {2'b00, in_rd, in_rs1, in_rs2};
            2'b10:   enc = {2'b10, in_rd, in_imm};
            2'b11:   enc = {2'b11, in_addr, in_rs2};
            default: enc = 8'h00;
        endcase

        fifo_cnt_n = fifo_cnt;
        if (push && !pop)
            fifo_cnt_n = fifo_cnt + CW'(1);
        else if (pop && !push)
            fifo_cnt_n = fifo_cnt - CW'(1);

        state_n     = state_q;
        legal_cnt_n = legal_cnt + (push ? 5'd1 : 5'd0);
        count_n     = count + (fire ? 5'd1 : 5'd0);
        addr_n      = mem_addr + (fire ? 4'd1 : 4'd0);
        err_n       = err_illegal || (accept && illegal);
        mem_we_n    = mem_we;
        wdata_n     = mem_wdata;

        // Output register refills from the FIFO head whenever it frees up
        if (pop) begin
            mem_we_n = 1'b1;
            wdata_n  = fifo_mem[rd_ptr];
        end else if (out_free) begin
            mem_we_n = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n     = S_LOAD;
                    count_n     = 5'd0;
                    addr_n      = 4'd0;
                    err_n       = 1'b0;
                    legal_cnt_n = 5'd0;
                end
            end
            S_LOAD: begin
                if (accept && (in_last || (push && legal_cnt == 5'(MEM_SIZE - 1))))
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty && out_free) begin
`ifdef NOP_PAD_EN
                    state_n = S_PAD;
`else
                    state_n = S_DONE;
`endif
                end
            end
`ifdef NOP_PAD_EN
            S_PAD: begin
                // One filler word in flight at a time; count_n tracks completed writes
                if (out_free) begin
                    if (count_n < 5'(MEM_SIZE)) begin
                        mem_we_n = 1'b1;
                        wdata_n  = 8'h00;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        in_ready_n = (state_n == S_LOAD) && (fifo_cnt_n != CW'(DEPTH));
`ifdef NOP_PAD_EN
        busy_n = (state_n == S_LOAD) || (state_n == S_DRAIN) || (state_n == S_PAD);
`else
        busy_n = (state_n == S_LOAD) || (state_n == S_DRAIN);
`endif
        done_n = (state_n == S_DONE);
    end

    // State, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            legal_cnt   <= 5'd0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 4'd0;
            mem_wdata   <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            count       <= 5'd0;
        end else begin
            state_q     <= state_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt    <= fifo_cnt_n;
            legal_cnt   <= legal_cnt_n;
            in_ready    <= in_ready_n;
            mem_we      <= mem_we_n;
            mem_addr    <= addr_n;
            mem_wdata   <= wdata_n;
            busy        <= busy_n;
            done        <= done_n;
            err_illegal <= err_n;
            count       <= count_n;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= enc;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus
// randomized programs checked against a word-level reference model.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    localparam int unsigned MEM_SIZE = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] in_opcode = 2'd0, in_rd = 2'd0, in_rs1 = 2'd0, in_rs2 = 2'd0;
    logic [3:0] in_addr = 4'd0, in_imm = 4'd0;
    logic       in_ready, mem_we, busy, done, err_illegal;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [4:0] count;

    int n_assert = 0;
    int n_fail   = 0;
    int ready_mode = 1;

    logic [7:0] exp_q[$];
    bit         exp_err;

    logic [3:0] obs_addr[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];
    int         cyc = 0;
    int         stall_viol = 0;
    int         rd_idx = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] p_addr = 4'd0;
    logic [7:0] p_data = 8'h00;

    instr_encoder_loader #(.DEPTH(4), .MEM_SIZE(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_addr(in_addr), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err_illegal(err_illegal), .count(count)
    );

    always #5 clk = ~clk;

    // Memory-side ready: held low, held high, or random ~70% accept
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       mem_ready = 1'b0;
            1:       mem_ready = 1'b1;
            default: mem_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Memory monitor: records completed writes and checks stall stability
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(mem_we === 1'b1 && mem_addr === p_addr && mem_wdata === p_data))
                stall_viol = stall_viol + 1;
            if (mem_we === 1'b1 && mem_ready === 1'b1) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_wdata);
                obs_cyc.push_back(cyc);
            end
            prev_stall = mem_we && !mem_ready;
            p_addr = mem_addr;
            p_data = mem_wdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference encoding from the instruction format, by plain arithmetic
    function automatic logic [7:0] enc(input logic [1:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic [3:0] a, input logic [3:0] im);
        int w;
        case (op)
            2'd0:    w = int'(rd) * 16 + int'(rs1) * 4 + int'(rs2);
            2'd2:    w = 128 + int'(rd) * 16 + int'(im);
            2'd3:    w = 192 + int'(a) * 4 + int'(rs2);
            default: w = 0;
        endcase
        return 8'(w);
    endfunction

    function automatic logic [1:0] rand_legal_op();
        int r;
        r = int'($urandom_range(0, 2));
        return (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_count", 32'(count), 0);
        chk("start_err", 32'(err_illegal), 0);
        chk("start_done", 32'(done), 0);
    endtask

    // Offer one bundle for up to budget cycles; model the accept if it happens
    task automatic send(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] a, input logic [3:0] im,
                        input logic lst, input int budget, output bit ok);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_addr = a; in_imm = im; in_last = lst;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (op == 2'b01) exp_err = 1'b1;
            else exp_q.push_back(enc(op, rd, rs1, rs2, a, im));
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic send_req(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic [3:0] a, input logic [3:0] im,
                            input logic lst);
        bit ok;
        send(op, rd, rs1, rs2, a, im, lst, 200, ok);
        chk("bundle_accepted", 32'(ok), 1);
    endtask

    task automatic send_rand(input logic [1:0] op, input logic lst);
        send_req(op, 2'($urandom), 2'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom), lst);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("done_reached", 32'(done), 1);
    endtask

    // Compare everything written this session against the model
    task automatic finish_session();
        int n_obs;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_done();
`ifdef NOP_PAD_EN
        while (exp_q.size() < MEM_SIZE) exp_q.push_back(8'h00);
`endif
        chk("end_count", 32'(count), 32'(exp_q.size()));
        chk("end_err", 32'(err_illegal), 32'(exp_err));
        chk("end_busy", 32'(busy), 0);
        chk("end_in_ready", 32'(in_ready), 0);
        chk("end_mem_we", 32'(mem_we), 0);
        n_obs = obs_data.size() - rd_idx;
        chk("write_count", 32'(n_obs), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            chk($sformatf("wr%0d_addr", i), 32'(obs_addr[rd_idx + i]), 32'(i));
            chk($sformatf("wr%0d_data", i), 32'(obs_data[rd_idx + i]), 32'(exp_q[i]));
        end
        rd_idx = obs_data.size();
        chk("stall_stable", 32'(stall_viol), 0);
    endtask

    initial begin
        bit ok;
        int accepted;
        int n;
        logic [1:0] op;

        // Reset values
        ready_mode = 1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_illegal), 0);
        chk("rst_count", 32'(count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Single add: latency and one-cycle write
        do_start();
        send_req(2'd0, 2'd1, 2'd2, 2'd3, 4'd0, 4'd0, 1'b1);
        in_valid = 1'b0;
        chk("lat_we_k", 32'(mem_we), 0);
        tick();
        chk("lat_we_k1", 32'(mem_we), 1);
        chk("lat_addr", 32'(mem_addr), 0);
        chk("lat_data", 32'(mem_wdata), 32'h1B);
        tick();
        chk("lat_we_k2", 32'(mem_we), 0);
        finish_session();

        // Back-to-back bundles with in_valid held
        do_start();
        send_req(2'd2, 2'd2, 2'd0, 2'd0, 4'd0, 4'hA, 1'b0);
        send_req(2'd3, 2'd0, 2'd0, 2'd1, 4'd5, 4'd0, 1'b0);
        send_req(2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
        in_valid = 1'b0;
        wait_done();
        chk("b2b_size", 32'(obs_data.size() >= rd_idx + 3), 1);
        if (obs_data.size() >= rd_idx + 3) begin
            chk("b2b_gap1", 32'(obs_cyc[rd_idx + 1] - obs_cyc[rd_idx]), 1);
            chk("b2b_gap2", 32'(obs_cyc[rd_idx + 2] - obs_cyc[rd_idx + 1]), 1);
        end
        finish_session();

        // Illegal opcode is swallowed and flagged
        do_start();
        send_rand(2'b01, 1'b0);
        chk("illegal_err_set", 32'(err_illegal), 1);
        send_req(2'd2, 2'd0, 2'd0, 2'd0, 4'd0, 4'd1, 1'b1);
        finish_session();

        // Capacity with memory stalled: DEPTH+1 accepted, head word held
        ready_mode = 0;
        tick();
        do_start();
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            send(rand_legal_op(), 2'($urandom), 2'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom), 1'b0, 4, ok);
            if (ok) accepted++;
        end
        chk("cap_accepted", 32'(accepted), 5);
        chk("cap_in_ready", 32'(in_ready), 0);
        chk("cap_we", 32'(mem_we), 1);
        chk("cap_addr", 32'(mem_addr), 0);
        chk("cap_data", 32'(mem_wdata), 32'(exp_q[0]));
        repeat (3) tick();
        chk("cap_data_held", 32'(mem_wdata), 32'(exp_q[0]));
        ready_mode = 1;
        send_rand(rand_legal_op(), 1'b1);
        finish_session();

        // MEM_SIZE legal limit, then restart clears count and error
        ready_mode = 2;
        do_start();
        send_rand(2'b01, 1'b0);
        for (int i = 0; i < 16; i++) send_rand(rand_legal_op(), 1'b0);
        send(rand_legal_op(), 2'd1, 2'd1, 2'd1, 4'd1, 4'd1, 1'b0, 5, ok);
        chk("limit_17th_refused", 32'(ok), 0);
        chk("limit_in_ready", 32'(in_ready), 0);
        finish_session();
        do_start();
        send_rand(rand_legal_op(), 1'b1);
        finish_session();

        // Reset during DRAIN discards buffered words
        ready_mode = 0;
        tick();
        do_start();
        send_rand(rand_legal_op(), 1'b0);
        send_rand(rand_legal_op(), 1'b0);
        send_rand(rand_legal_op(), 1'b1);
        in_valid = 1'b0;
        chk("drain_busy", 32'(busy), 1);
        chk("drain_in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_no_writes", 32'(obs_data.size()), 32'(rd_idx));
        ready_mode = 1;
        tick();
        chk("mid_rst_idle", 32'(busy), 0);

        // Two-word program (exercises fill when padding is built in)
        do_start();
        send_rand(rand_legal_op(), 1'b0);
        send_rand(rand_legal_op(), 1'b1);
        finish_session();

        // Randomized programs with random stalls and idle gaps
        ready_mode = 2;
        for (int s = 0; s < 6; s++) begin
            do_start();
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) begin
                op = 2'($urandom);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                send_rand(op, (i == n - 1));
            end
            finish_session();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the 8-bit instruction decoder. Accepts decoded instruction fields (opcode, rd, rs1, rs2, addr, imm) over a valid/ready stream and packs each into an 8-bit instruction word. Buffers the words in a small FIFO and writes them sequentially into the 16-entry program memory through a stallable write port. Used by the bench/loader path to build programs for the CPU from field-level descriptions.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
MEM_SIZE, 16, program memory words; max 16, set by the 4-bit addr field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a load session from IDLE or DONE
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle
in_opcode  in  2  00 add, 10 li, 11 bner0, 01 illegal
in_rd  in  2  destination register
in_rs1  in  2  source register 1
in_rs2  in  2  source register 2
in_addr  in  4  branch target
in_imm  in  4  immediate
in_last  in  1  final bundle of the program
mem_we  out  1  write request, held until mem_ready
mem_ready  in  1  memory accepts the write this cycle
mem_addr  out  4  write address
mem_wdata  out  8  encoded instruction
busy  out  1  high in LOAD, DRAIN, PAD
done  out  1  level, high in DONE
err_illegal  out  1  sticky; an opcode 01 bundle was received
count  out  5  words written to memory this session (0..16)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: state IDLE, FIFO empty, output register empty. mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, err_illegal=0, count=0.
- Encoding:
  - add: {00, rd, rs1, rs2}
  - li: {10, rd, imm}
  - bner0: {11, addr, rs2}
  - Fields not used by the opcode are ignored.
- States:
  - IDLE: start goes to LOAD.
  - LOAD: in_ready = !fifo_full. Goes to DRAIN on the accept of a bundle with in_last=1, or on the accept of the MEM_SIZE-th legal bundle.
  - DRAIN: in_ready=0. Goes to DONE (or PAD, see optional feature) when the FIFO is empty and the final write has completed.
  - DONE: start goes to LOAD.
  - On entry to LOAD: clear count, err_illegal and the address counter.
  - start is ignored in LOAD, DRAIN and PAD.
- Accept: handshake completes when in_valid && in_ready.
  - Legal opcode: the encoded word is pushed into the FIFO.
  - Opcode 01: handshake still completes, nothing is pushed, err_illegal set (sticky until the next start or rst). in_last on an illegal bundle still ends LOAD.
- Output register:
  - Loads the FIFO head when it is empty, or when mem_we && mem_ready in the same cycle.
  - mem_we/mem_addr/mem_wdata stay stable while mem_we && !mem_ready.
  - mem_addr increments and count increments on each mem_we && mem_ready.
- Latency: with the FIFO empty and mem_ready=1, a word accepted at edge k drives mem_we in the cycle after edge k+1. Throughput is 1 word/cycle.
- Capacity: the FIFO holds DEPTH words plus one in the output register. No push-through when the FIFO is full; in_ready depends on full only.
- mem_addr is 4 bits and never wraps within a session: the LOAD limit is MEM_SIZE legal bundles.
- rst mid-session: immediate return to the reset state, buffered words discarded, mem_we=0 in the next cycle.

Optional Feature:
NOP_PAD_EN:
- Defined: DRAIN completion enters state PAD, which writes 8'h00 (add r0,r0,r0) to every remaining address up to MEM_SIZE-1, one per accepted write, then goes to DONE. count ends at MEM_SIZE.
- Not defined: DRAIN goes straight to DONE, the remaining locations are untouched, and no PAD state exists.

Test Plan:
- rst, start, add rd=1 rs1=2 rs2=3 with last, mem_ready=1 -> mem_wdata=8'h1B, mem_addr=0, mem_we for one cycle after edge k+1; done=1, count=1.
- Back-to-back li rd=2 imm=A, bner0 addr=5 rs2=1, add 0/0/0(last), in_valid held -> writes 8'hAA, 8'hD5, 8'h00 at addresses 0, 1, 2 on consecutive cycles; count=3.
- Opcode 01 bundle, then li rd=0 imm=1 (last) -> err_illegal=1 held, single write 8'h81 at addr 0, count=1.
- mem_ready=0 from start, 8 bundles offered -> exactly DEPTH+1=5 accepted then in_ready=0; mem_we held with 1st word stable; on mem_ready=1, words written in order at addresses 0..4.
- 17 legal bundles without last -> in_ready=0 after the 16th accept, addresses 0..15 written, done=1, count=16; next start clears count and err_illegal.
- rst asserted in DRAIN with 3 words buffered -> mem_we=0 next cycle, state IDLE, count=0. NOP_PAD_EN build with 2-word program -> addresses 2..15 written 8'h00, count=16.
